// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared widths, defaults and the divide-value rule for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int CLKDIV_CNT_W       = 32;
    localparam int CLKDIV_DIV_DEFAULT = 50_000;

    typedef logic [CLKDIV_CNT_W-1:0] cnt_t;

    // A programmed half-period of zero behaves like one: tick every cycle.
    function automatic cnt_t div_eff(input cnt_t div);
        return (div == '0) ? cnt_t'(1) : div;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one programmable divider channel (counter, active/pending divide, tick, square wave).
// Optional phase-align strobe enabled by defining CLKDIV_SYNC_EN; CNT_W must not exceed the package width.
module clkdiv_channel #(
    parameter int CNT_W       = clkdiv_pkg::CLKDIV_CNT_W,
    parameter int DIV_DEFAULT = clkdiv_pkg::CLKDIV_DIV_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_div,
    input  logic             i_sync,
    output logic             o_tick,
    output logic             o_clk
);
    import clkdiv_pkg::*;

    logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d, lim;
    logic             pend_vld_q, pend_vld_d, tick_q, tick_d, clk_q, clk_d, tc;

    assign lim    = CNT_W'(div_eff(cnt_t'(div_q))) - CNT_W'(1);
    assign tc     = i_en && (cnt_q == lim);
    assign o_tick = tick_q;
    assign o_clk  = clk_q;

`ifndef CLKDIV_SYNC_EN
    logic unused_sync;
    assign unused_sync = i_sync;
`endif

    // Next state: count/terminal, load into pending or bypass at terminal, apply pending when idle.
    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        tick_d     = 1'b0;
        clk_d      = clk_q;
        if (i_en) begin
            cnt_d  = tc ? '0 : cnt_q + CNT_W'(1);
            tick_d = tc;
            clk_d  = clk_q ^ tc;
            if (tc && (i_load || pend_vld_q)) begin
                div_d      = i_load ? i_load_div : pend_q;
                pend_vld_d = 1'b0;
            end else if (i_load) begin
                pend_d     = i_load_div;
                pend_vld_d = 1'b1;
            end
        end else begin
            if (pend_vld_q) begin
                div_d      = pend_q;
                pend_vld_d = 1'b0;
                cnt_d      = '0;
            end
            if (i_load) begin
                pend_d     = i_load_div;
                pend_vld_d = 1'b1;
            end
        end
`ifdef CLKDIV_SYNC_EN
        if (i_sync) begin
            cnt_d      = '0;
            clk_d      = 1'b0;
            tick_d     = 1'b0;
            div_d      = div_q;
            pend_d     = i_load ? i_load_div : pend_q;
            pend_vld_d = pend_vld_q | i_load;
        end
`endif
    end

    // Channel state registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q      <= '0;
            div_q      <= CNT_W'(DIV_DEFAULT);
            pend_q     <= CNT_W'(DIV_DEFAULT);
            pend_vld_q <= 1'b0;
            tick_q     <= 1'b0;
            clk_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            tick_q     <= tick_d;
            clk_q      <= clk_d;
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: N_CH runtime-programmable clock dividers with tick and 50%-duty outputs.
// Phase-align strobe i_sync is honoured only when CLKDIV_SYNC_EN is defined.
module clock_divider_multi #(
    parameter  int N_CH        = 4,
    parameter  int CNT_W       = clkdiv_pkg::CLKDIV_CNT_W,
    parameter  int DIV_DEFAULT = clkdiv_pkg::CLKDIV_DIV_DEFAULT,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [N_CH-1:0]  i_en,
    input  logic             i_load,
    input  logic [CH_W-1:0]  i_load_ch,
    input  logic [CNT_W-1:0] i_load_div,
    input  logic             i_sync,
    output logic             o_load_ack,
    output logic [N_CH-1:0]  o_tick,
    output logic [N_CH-1:0]  o_clk
);

    logic load_ok, load_ack_q, load_ack_d;

    assign load_ok    = i_load && (int'(i_load_ch) < N_CH);
    assign load_ack_d = load_ok;
    assign o_load_ack = load_ack_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_ch (
            .i_clk      (i_clk),
            .i_reset_n  (i_reset_n),
            .i_en       (i_en[c]),
            .i_load     (load_ok && (i_load_ch == CH_W'(c))),
            .i_load_div (i_load_div),
            .i_sync     (i_sync),
            .o_tick     (o_tick[c]),
            .o_clk      (o_clk[c])
        );
    end

    // Acknowledge an in-range load one cycle after it is taken.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) load_ack_q <= 1'b0;
        else            load_ack_q <= load_ack_d;
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed scoreboard bench for clock_divider_multi (3 channels, default half-period 4).
module tb_clock_divider_multi;

    localparam int N_CH = 3;

    logic            i_clk = 1'b0;
    logic            i_reset_n = 1'b0;
    logic [N_CH-1:0] i_en;
    logic            i_load = 1'b0;
    logic [1:0]      i_load_ch;
    logic [31:0]     i_load_div;
    logic            i_sync = 1'b0;
    logic            o_load_ack;
    logic [N_CH-1:0] o_tick, o_clk;

    typedef struct {
        string tag;
        int    ch;
        logic  tick;
        logic  clk;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0, m_cnt = 0, ncyc = 0;
    logic m_clk = 1'b0;

    clock_divider_multi #(.N_CH(N_CH), .CNT_W(32), .DIV_DEFAULT(4)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_en       (i_en),
        .i_load     (i_load),
        .i_load_ch  (i_load_ch),
        .i_load_div (i_load_div),
        .i_sync     (i_sync),
        .o_load_ack (o_load_ack),
        .o_tick     (o_tick),
        .o_clk      (o_clk)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int ch, input logic tick, input logic clk);
        exp_t e;
        e.tag  = tag;
        e.ch   = ch;
        e.tick = tick;
        e.clk  = clk;
        sb.push_back(e);
    endtask

    // Expected edges of an enabled channel with half-period d, continuing from m_cnt/m_clk.
    task automatic plan(input string tag, input int ch, input int n, input int d);
        for (int i = 0; i < n; i++) begin
            if (m_cnt == d - 1) begin
                m_cnt = 0;
                m_clk = ~m_clk;
                push(tag, ch, 1'b1, m_clk);
            end else begin
                m_cnt++;
                push(tag, ch, 1'b0, m_clk);
            end
        end
    endtask

    // Expected edges of a disabled channel: no tick, square wave held.
    task automatic hold(input string tag, input int ch, input int n);
        for (int i = 0; i < n; i++) push(tag, ch, 1'b0, m_clk);
    endtask

    task automatic advance(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
            ncyc++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_empty observed=0 expected=1");
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_tick"}, 32'(o_tick[e.ch]), 32'(e.tick));
                chk({e.tag, "_clk"}, 32'(o_clk[e.ch]), 32'(e.clk));
            end
        end
    endtask

    initial begin
        i_en       = 3'b011;
        i_load_ch  = 2'd0;
        i_load_div = 32'd0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_tick", 32'(o_tick), 32'd0);
        chk("rst_clk", 32'(o_clk), 32'd0);
        chk("rst_ack", 32'(o_load_ack), 32'd0);

        // Default half-period 4: tick every 4 cycles, square wave period 8.
        i_reset_n = 1'b1;
        ncyc  = 0;
        m_cnt = 0;
        m_clk = 1'b0;
        plan("s1_ch0", 0, 16, 4);
        advance(16);

        // Load ch1 = 3 at cnt 1: current period finishes at 4, then every 3.
        m_cnt = 0;
        m_clk = 1'b0;
        plan("s2_pre", 1, 1, 4);
        advance(1);
        i_load     = 1'b1;
        i_load_ch  = 2'd1;
        i_load_div = 32'd3;
        plan("s2_ld", 1, 1, 4);
        advance(1);
        chk("s2_ack", 32'(o_load_ack), 32'd1);
        i_load = 1'b0;
        plan("s2_old", 1, 1, 4);
        advance(1);
        chk("s2_ack_drop", 32'(o_load_ack), 32'd0);
        plan("s2_old", 1, 1, 4);
        plan("s2_new", 1, 9, 3);
        advance(10);

        // ch2 (disabled since reset): load 0 applies while idle, then 1 bypasses at terminal.
        m_cnt      = 0;
        m_clk      = 1'b0;
        i_load     = 1'b1;
        i_load_ch  = 2'd2;
        i_load_div = 32'd0;
        hold("s3_idle", 2, 1);
        advance(1);
        chk("s3_ack0", 32'(o_load_ack), 32'd1);
        i_load = 1'b0;
        hold("s3_apply", 2, 1);
        advance(1);
        i_en  = 3'b111;
        m_cnt = 0;
        plan("s3_div0", 2, 6, 1);
        advance(6);
        i_load     = 1'b1;
        i_load_div = 32'd1;
        plan("s3_ld1", 2, 1, 1);
        advance(1);
        chk("s3_ack1", 32'(o_load_ack), 32'd1);
        i_load = 1'b0;
        plan("s3_div1", 2, 6, 1);
        advance(6);

        // ch0 paused at cnt 2 for 10 cycles, then next tick 2 cycles after re-enable.
        m_cnt = ncyc % 4;
        m_clk = 1'((ncyc / 4) % 2);
        while (m_cnt != 2) begin
            plan("s4_align", 0, 1, 4);
            advance(1);
        end
        i_en[0] = 1'b0;
        hold("s4_hold", 0, 10);
        advance(10);
        i_en[0] = 1'b1;
        plan("s4_resume", 0, 8, 4);
        advance(8);

        // Out-of-range channel: no ack, ch0 timing untouched.
        i_load     = 1'b1;
        i_load_ch  = 2'd3;
        i_load_div = 32'd7;
        plan("s5_bad", 0, 1, 4);
        advance(1);
        chk("s5_noack", 32'(o_load_ack), 32'd0);
        i_load = 1'b0;
        plan("s5_keep", 0, 8, 4);
        advance(8);
        while (m_clk !== 1'b1) begin
            plan("s5_align", 0, 1, 4);
            advance(1);
        end

        // Asynchronous reset mid-count clears outputs without a clock edge.
        i_reset_n = 1'b0;
        #1;
        chk("s5_rst_tick", 32'(o_tick), 32'd0);
        chk("s5_rst_clk", 32'(o_clk), 32'd0);
        chk("s5_rst_ack", 32'(o_load_ack), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        m_cnt = 0;
        m_clk = 1'b0;
        plan("s5_ch2_dflt", 2, 8, 4);
        advance(8);
        chk("sb_drain", 32'(sb.size()), 32'd0);

`ifdef CLKDIV_SYNC_EN
        // ch0 = 5, ch1 = 10 started at an offset, then phase-aligned by i_sync.
        i_en       = 3'b000;
        i_load     = 1'b1;
        i_load_ch  = 2'd0;
        i_load_div = 32'd5;
        @(posedge i_clk);
        #1;
        i_load_ch  = 2'd1;
        i_load_div = 32'd10;
        @(posedge i_clk);
        #1;
        i_load = 1'b0;
        @(posedge i_clk);
        #1;
        i_en = 3'b001;
        repeat (3) @(posedge i_clk);
        #1;
        i_en = 3'b011;
        repeat (7) @(posedge i_clk);
        #1;
        i_sync = 1'b1;
        @(posedge i_clk);
        #1;
        i_sync = 1'b0;
        chk("s6_sync_clk", 32'(o_clk[1:0]), 32'd0);
        chk("s6_sync_tick", 32'(o_tick[1:0]), 32'd0);
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk);
            #1;
            chk("s6_clk0", 32'(o_clk[0]), 32'((k / 5) % 2));
            chk("s6_clk1", 32'(o_clk[1]), 32'((k / 10) % 2));
            chk("s6_tick0", 32'(o_tick[0]), 32'(k % 5 == 0));
            chk("s6_tick1", 32'(o_tick[1]), 32'(k % 10 == 0));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
